hcs_alarm_transmitter: RTL and testbench
========================================

// Module: hcs_alarm_transmitter
// PURPOSE
//  Far-end partner of healthCareSystem: consumes its four abnormality flags and glycemicIndex and
//  serialises them to the nurse-station link as an asynchronous (UART-style) frame.
//  Sends one frame per change of the status word, plus on explicit request.
//  Sits between healthCareSystem outputs and the board-level TX pin; same clock domain as the HCS.
// PARAMETERS
//  CLKS_PER_BIT   16  clocks per serial bit; legal >= 2
//  STOP_BITS      1   stop bits per frame; legal 1..2
// PORTS
//  clk                     in   1  system clock, rising edge
//  rstN                    in   1  asynchronous, active-low reset
//  presureAbnormality      in   1  from healthCareSystem
//  bloodAbnormality        in   1  from healthCareSystem
//  fallDetected            in   1  from healthCareSystem
//  temperatureAbnormality  in   1  from healthCareSystem
//  glycemicIndex           in   4  from healthCareSystem
//  sendNow                 in   1  one-cycle request: resend current status word even if unchanged
//  txSerial                out  1  serial line, idle high
//  txBusy                  out  1  high while a frame is on the line (START..last STOP)
//  alarmActive             out  1  registered OR of the four flags in the input stage
//  frameCount              out  8  frames completed, wraps 255->0
// BEHAVIOUR
//  Reset: one clock and reset; rstN is asynchronous, active-low. While rstN=0: txSerial=1, txBusy=0,
//   alarmActive=0, frameCount=0, inReg=0, lastSent=0, sendReq=0, state=IDLE. A mid-frame reset
//   aborts the frame at once. No frame is sent after reset while the status word stays 0.
//  Status word: payload[7:0] = {glycemicIndex[3:0], temperatureAbnormality, fallDetected,
//   bloodAbnormality, presureAbnormality}. It is registered into inReg every clock.
//   alarmActive = |inReg[3:0].
//  sendNow sets sendReq on any cycle, busy or idle. sendReq is cleared when a frame starts.
//  Trigger, in IDLE only: (inReg != lastSent) || sendReq. On a trigger edge: shiftReg<=inReg,
//   lastSent<=inReg, sendReq<=0, state<=START.
//  Latency: input change before edge k -> inReg at k -> START at k+1 -> txSerial=0 after k+1.
//  FSM (each state except IDLE lasts CLKS_PER_BIT clocks; bit counter 0..CLKS_PER_BIT-1):
//   IDLE   txSerial=1, txBusy=0; on trigger -> START
//   START  txSerial=0 -> DATA
//   DATA   txSerial=shiftReg[bitIdx], LSB first, bitIdx 0..7 -> PARITY if enabled, else STOP
//   PARITY txSerial=^shiftReg (even parity) -> STOP
//   STOP   txSerial=1 for STOP_BITS bit times; on the final clock frameCount+=1 -> IDLE
//  txBusy=1 in START..STOP inclusive.
//  Inputs that change during a frame do not affect the frame in flight. Any difference from
//   lastSent re-triggers in the first IDLE cycle after STOP, so only the latest word is sent.
//   Intermediate values are dropped by design.
//  Back-to-back: minimum line idle between frames is 1 clock (the IDLE trigger cycle).
//  Simultaneous change + sendNow: produces exactly one frame.
// CONFIGURATION
//  HCS_TX_PARITY_EN defined: PARITY state present; frame = 1+8+1+STOP_BITS bits.
//  HCS_TX_PARITY_EN undefined: PARITY state and its logic removed; DATA goes straight to STOP;
//   frame = 1+8+STOP_BITS bits.
// TESTING  (CLKS_PER_BIT=4, STOP_BITS=1, HCS_TX_PARITY_EN defined unless noted)
//  1 Reset, all inputs 0, run 200 clk -> txSerial stays 1, txBusy=0, frameCount=0.
//  2 fallDetected=1, glycemicIndex=9 -> payload 0x94; line carries 0,0,0,1,0,1,0,0,1,1,1
//    (each bit 4 clk); frame is 44 clk; frameCount=1; alarmActive=1.
//  3 Mid-frame, change to bloodAbnormality=1, GI=0 -> first frame completes unchanged;
//    second frame 0x02 with parity 1 starts 1 clk after STOP; frameCount=2.
//  4 Inputs stable, pulse sendNow -> one frame repeating lastSent. sendNow pulsed twice
//    during that frame -> exactly one further frame.
//  5 Drop rstN during DATA bit 3 -> txSerial=1, txBusy=0 asynchronously.
//    After release with payload 0x94 held -> fresh full frame, since lastSent was cleared.
//  6 HCS_TX_PARITY_EN undefined, payload 0x94 -> 40 clk frame, no parity bit.
//    Also 256 frames -> frameCount wraps to 0.

Source files
------------

// File: rtl/hcs_alarm_transmitter_if.sv
// Status/serial bundle between healthCareSystem (master) and the alarm transmitter (slave).
interface hcs_alarm_transmitter_if;
  logic       presureAbnormality;
  logic       bloodAbnormality;
  logic       fallDetected;
  logic       temperatureAbnormality;
  logic [3:0] glycemicIndex;
  logic       sendNow;
  logic       txSerial;
  logic       txBusy;
  logic       alarmActive;
  logic [7:0] frameCount;

  modport master (
    output presureAbnormality, bloodAbnormality, fallDetected, temperatureAbnormality,
    output glycemicIndex, sendNow,
    input  txSerial, txBusy, alarmActive, frameCount
  );

  modport slave (
    input  presureAbnormality, bloodAbnormality, fallDetected, temperatureAbnormality,
    input  glycemicIndex, sendNow,
    output txSerial, txBusy, alarmActive, frameCount
  );
endinterface

// File: rtl/hcs_alarm_transmitter.sv
// Serialises the healthCareSystem status word as a UART-style frame on change or on request.
// Optional even-parity bit is built when HCS_TX_PARITY_EN is defined.
module hcs_alarm_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                     clk,
  input  logic                     rstN,
  hcs_alarm_transmitter_if.slave   bus
);

  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned WORD_W   = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST       = 1'(STOP_BITS - 1);

`ifdef HCS_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [WORD_W-1:0] payload;
  logic [WORD_W-1:0] in_reg;
  logic [WORD_W-1:0] last_sent;
  logic [WORD_W-1:0] shift_reg;
  logic              send_req;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_idx;
  logic              stop_idx;
  logic              tx_serial;
  logic              tx_busy;
  logic              alarm;
  logic [7:0]        frame_count;
`ifdef HCS_TX_PARITY_EN
  logic              parity_bit;
`endif

  logic trigger_c;
  logic bit_done_c;

  assign payload = {bus.glycemicIndex, bus.temperatureAbnormality, bus.fallDetected,
                    bus.bloodAbnormality, bus.presureAbnormality};

  assign trigger_c  = (state == IDLE) && ((in_reg != last_sent) || send_req);
  assign bit_done_c = (clk_cnt == CNT_LAST);

  assign bus.txSerial    = tx_serial;
  assign bus.txBusy      = tx_busy;
  assign bus.alarmActive = alarm;
  assign bus.frameCount  = frame_count;

  // Input stage: sample the status word; alarm tracks the OR of the four flags held in in_reg.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      in_reg <= '0;
      alarm  <= 1'b0;
    end else begin
      in_reg <= payload;
      alarm  <= |payload[3:0];
    end
  end

  // Resend request: latched on any cycle, consumed when a frame starts.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      send_req <= 1'b0;
    end else if (trigger_c) begin
      send_req <= 1'b0;
    end else if (bus.sendNow) begin
      send_req <= 1'b1;
    end
  end

  // Frame sequencer: each non-IDLE state holds the line for CLKS_PER_BIT clocks.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      last_sent   <= '0;
      shift_reg   <= '0;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      tx_serial   <= 1'b1;
      tx_busy     <= 1'b0;
      frame_count <= '0;
`ifdef HCS_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
          clk_cnt   <= '0;
          if (trigger_c) begin
            shift_reg <= in_reg;
            last_sent <= in_reg;
`ifdef HCS_TX_PARITY_EN
            parity_bit <= ^in_reg;
`endif
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_done_c) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            tx_serial <= shift_reg[0];
            state     <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done_c) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef HCS_TX_PARITY_EN
              tx_serial <= parity_bit;
              state     <= PARITY;
`else
              tx_serial <= 1'b1;
              stop_idx  <= 1'b0;
              state     <= STOP;
`endif
            end else begin
              // Shift so the next bit is always at [0]; the bit after it drives the line now.
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx_serial <= shift_reg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef HCS_TX_PARITY_EN
        PARITY: begin
          if (bit_done_c) begin
            clk_cnt   <= '0;
            tx_serial <= 1'b1;
            stop_idx  <= 1'b0;
            state     <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done_c) begin
            clk_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              tx_busy     <= 1'b0;
              frame_count <= frame_count + 1'b1;
              state       <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hcs_alarm_transmitter.sv
// Bench for hcs_alarm_transmitter: table of status words plus hand sequences,
// with a line decoder that pops expected frames from a scoreboard queue.
module tb_hcs_alarm_transmitter;

  localparam int CPB = 4;
`ifdef HCS_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = 10 + PAR;
  localparam int FRAME_CLKS = CPB * FRAME_BITS;

  typedef struct {
    logic [7:0] payload;
    logic       send;
    logic       exp_frame;
    logic       exp_alarm;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rstN;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  logic [7:0] exp_fc;
  vec_t vecs[10];

  int   cyc = 0;
  logic mon_active = 1'b0;
  int   mon_cnt = 0;
  logic [7:0] mon_data;
  logic busy_bad;
  int   prev_start = 0;
  int   last_start = 0;
`ifdef HCS_TX_PARITY_EN
  logic mon_par;
`endif

  hcs_alarm_transmitter_if bus();

  hcs_alarm_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic set_payload(input logic [7:0] p);
    bus.presureAbnormality     = p[0];
    bus.bloodAbnormality       = p[1];
    bus.fallDetected           = p[2];
    bus.temperatureAbnormality = p[3];
    bus.glycemicIndex          = p[7:4];
  endtask

  task automatic push_frame(input logic [7:0] p);
    exp_t e;
    exp_fc = exp_fc + 8'd1;
    e.data = p;
    e.fc   = exp_fc;
    exp_q.push_back(e);
  endtask

  task automatic wait_busy(input string name);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.txBusy === 1'b1) break;
    end
    if (i == 20) fail_now(name);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < budget && !done; i++) begin
      if (exp_q.size() == 0 && bus.txBusy === 1'b0 && !mon_active) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) fail_now("drain_timeout");
    check("frame_count", 32'(bus.frameCount), 32'(exp_fc));
  endtask

  // Line decoder: samples mid-bit, checks framing, compares against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   bi;
    cyc++;
    if (!rstN) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (bus.txSerial === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_data   = '0;
        busy_bad   = 1'b0;
        prev_start = last_start;
        last_start = cyc;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt < FRAME_CLKS && bus.txBusy !== 1'b1) busy_bad = 1'b1;
      if (mon_cnt < FRAME_CLKS && (mon_cnt % CPB) == CPB / 2) begin
        bi = mon_cnt / CPB;
        if (bi == 0) check("start_bit", 32'(bus.txSerial), 32'd0);
        else if (bi <= 8) mon_data[3'(bi - 1)] = bus.txSerial;
`ifdef HCS_TX_PARITY_EN
        else if (bi == 9) mon_par = bus.txSerial;
`endif
        else check("stop_bit", 32'(bus.txSerial), 32'd1);
      end
      if (mon_cnt == FRAME_CLKS) begin
        mon_active = 1'b0;
        check("frame_busy_span", 32'(busy_bad), 32'd0);
        check("frame_end_busy", 32'(bus.txBusy), 32'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_frame");
        end else begin
          e = exp_q.pop_front();
          check("frame_data", 32'(mon_data), 32'(e.data));
`ifdef HCS_TX_PARITY_EN
          check("frame_parity", 32'(mon_par), 32'(^e.data));
`endif
          check("frame_count_at_end", 32'(bus.frameCount), 32'(e.fc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic line_bad;
    logic [7:0] fc0;

    vecs[0] = '{8'h94, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'h94, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h94, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h10, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{8'h08, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'h00, 1'b0, 1'b0, 1'b0};

    exp_fc = 8'd0;
    rstN = 1'b0;
    set_payload(8'h00);
    bus.sendNow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.txSerial), 32'd1);
    check("rst_busy", 32'(bus.txBusy), 32'd0);
    check("rst_fc", 32'(bus.frameCount), 32'd0);
    check("rst_alarm", 32'(bus.alarmActive), 32'd0);
    rstN = 1'b1;

    // Zero status word after reset: the line must stay idle.
    line_bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (bus.txSerial !== 1'b1 || bus.txBusy !== 1'b0) line_bad = 1'b1;
    end
    check("idle_after_reset", 32'(line_bad), 32'd0);
    check("idle_fc", 32'(bus.frameCount), 32'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_payload(vecs[i].payload);
      bus.sendNow = vecs[i].send;
      if (vecs[i].exp_frame) push_frame(vecs[i].payload);
      @(negedge clk);
      bus.sendNow = 1'b0;
      @(negedge clk);
      check("vec_alarm", 32'(bus.alarmActive), 32'(vecs[i].exp_alarm));
      drain(200);
    end

    // Latency: change before edge k, line drops after edge k+1.
    @(negedge clk);
    set_payload(8'h02);
    push_frame(8'h02);
    @(negedge clk);
    check("lat_k_tx", 32'(bus.txSerial), 32'd1);
    check("lat_k_busy", 32'(bus.txBusy), 32'd0);
    check("lat_k_alarm", 32'(bus.alarmActive), 32'd1);
    @(negedge clk);
    check("lat_k1_tx", 32'(bus.txSerial), 32'd0);
    check("lat_k1_busy", 32'(bus.txBusy), 32'd1);
    drain(200);

    // Mid-frame change: frame in flight unaffected, new word follows after one idle clock.
    @(negedge clk);
    set_payload(8'h94);
    push_frame(8'h94);
    wait_busy("wait_busy_t3");
    repeat (12) @(negedge clk);
    set_payload(8'h02);
    push_frame(8'h02);
    drain(300);
    check("b2b_gap", 32'(last_start - prev_start), 32'(FRAME_CLKS + 1));

    // sendNow with stable word, then two pulses during that frame -> one more frame.
    @(negedge clk);
    bus.sendNow = 1'b1;
    push_frame(8'h02);
    @(negedge clk);
    bus.sendNow = 1'b0;
    wait_busy("wait_busy_t4");
    repeat (8) @(negedge clk);
    bus.sendNow = 1'b1;
    @(negedge clk);
    bus.sendNow = 1'b0;
    repeat (8) @(negedge clk);
    bus.sendNow = 1'b1;
    push_frame(8'h02);
    @(negedge clk);
    bus.sendNow = 1'b0;
    drain(300);

    // Reset during DATA bit 3 aborts at once; word held afterwards is sent fresh.
    @(negedge clk);
    set_payload(8'h00);
    push_frame(8'h00);
    drain(200);
    @(negedge clk);
    set_payload(8'h94);
    push_frame(8'h94);
    wait_busy("wait_busy_t5");
    repeat (17) @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    check("abort_tx", 32'(bus.txSerial), 32'd1);
    check("abort_busy", 32'(bus.txBusy), 32'd0);
    check("abort_fc", 32'(bus.frameCount), 32'd0);
    exp_q.delete();
    exp_fc = 8'd0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    push_frame(8'h94);
    drain(200);

    // 256 requested frames bring frameCount back to its starting value.
    fc0 = exp_fc;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bus.sendNow = 1'b1;
      push_frame(8'h94);
      @(negedge clk);
      bus.sendNow = 1'b0;
      drain(120);
    end
    check("fc_wrap", 32'(bus.frameCount), 32'(fc0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
